reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit_pkg.sv | 7 +
 rtl/reg_dump_unit_next_set_bit.sv | 20 ++
 rtl/reg_dump_unit.sv | 83 ++++++++
 tb/tb_reg_dump_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_unit_pkg.sv
// reg_dump_unit_pkg: shared sizes and FSM state encoding for the register dump unit.
package reg_dump_unit_pkg;
  localparam int NUM_REGS = 8;
  localparam int WORD_W = 16;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
endpackage

// File: rtl/reg_dump_unit_next_set_bit.sv
// next_set_bit: lowest set mask bit at or above from_idx (inclusive) or strictly above it.
module next_set_bit
  import reg_dump_unit_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic [IDX_W-1:0]    from_idx,
  input  logic                inclusive,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (mask[i] && (i > int'(from_idx) || (inclusive && i == int'(from_idx)))) begin
        found = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: streams the masked registers of a register file out over a valid/ready port.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [NUM_REGS-1:0] Mask,
  output logic [IDX_W-1:0]    SR_ADDR,
  input  logic [WORD_W-1:0]   SR_DATA,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [WORD_W-1:0]   Out_Data,
  output logic [IDX_W-1:0]    Out_Index,
  output logic                Out_Last,
  output logic                Busy,
  output logic                Done,
  output logic [WORD_W-1:0]   Checksum
);
  state_t state, state_nxt;
  logic [NUM_REGS-1:0] mask_q, srch_mask;
  logic [IDX_W-1:0] idx, srch_from, srch_idx;
  logic srch_found, idle;
  assign idle = state == IDLE;
  // In IDLE the search looks for the first bit of the incoming mask; afterwards for the bit above idx.
  assign srch_mask = idle ? Mask : mask_q;
  assign srch_from = idle ? '0 : idx;
  next_set_bit u_search (
    .mask(srch_mask),
    .from_idx(srch_from),
    .inclusive(idle),
    .found(srch_found),
    .idx(srch_idx)
  );
  assign Out_Valid = state == SEND;
  assign Busy = !idle;
  assign Done = state == DONE;
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = Start ? (Mask != '0 ? LOAD : DONE) : IDLE;
      LOAD: state_nxt = SEND;
      SEND: state_nxt = Out_Ready ? (Out_Last ? DONE : LOAD) : SEND;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      mask_q <= '0;
      idx <= '0;
      SR_ADDR <= '0;
      Out_Data <= '0;
      Out_Index <= '0;
      Out_Last <= 1'b0;
      Checksum <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          mask_q <= Mask;
          Checksum <= '0;
          idx <= srch_idx;
          SR_ADDR <= srch_idx;
        end
        LOAD: begin
          Out_Data <= SR_DATA;
          Out_Index <= idx;
          Out_Last <= !srch_found;
        end
        SEND: if (Out_Ready) begin
          Checksum <= Checksum + Out_Data;
          if (!Out_Last) begin
            idx <= srch_idx;
            SR_ADDR <= srch_idx;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: directed scenario tests for reg_dump_unit against a behavioural register file.
module tb_reg_dump_unit;
  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Out_Ready = 1'b0;
  logic [7:0] Mask = '0;
  logic [2:0] SR_ADDR, Out_Index;
  logic [15:0] SR_DATA, Out_Data, Checksum;
  logic Out_Valid, Out_Last, Busy, Done;
  logic [15:0] rf [8];
  int tests = 0, fails = 0;

  assign SR_DATA = rf[SR_ADDR];
  always #5 Clk = ~Clk;

  reg_dump_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mask(Mask),
    .SR_ADDR(SR_ADDR), .SR_DATA(SR_DATA),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Out_Index(Out_Index), .Out_Last(Out_Last),
    .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    Mask = 8'hFF;
    tick();
    tick();
    tests++;
    if ({SR_ADDR, Out_Valid, Out_Data, Out_Index, Out_Last, Busy, Done, Checksum} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b cs=%h, want all 0",
               SR_ADDR, Out_Valid, Out_Data, Out_Index, Out_Last, Busy, Done, Checksum);
    end
    Reset = 1'b0;
    Start = 1'b0;
    Mask = '0;
    tick();
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: Busy=%b want 0", Busy);
    end
  endtask

  task automatic test_full_dump();
    int words = 0, dones = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    Out_Ready = 1'b1;
    Mask = 8'hFF;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Mask = 8'h01;
    for (int c = 0; c < 40; c++) begin
      if (Done) dones++;
      if (Out_Valid) begin
        tests++;
        if (Out_Index !== 3'(words) || Out_Data !== 16'h1000 + 16'(words) ||
            Out_Last !== (words == 7) || c != 2 * words + 1) begin
          fails++;
          $display("FAIL full_word%0d: got idx=%0d data=%h last=%b cycle=%0d, want idx=%0d data=%h last=%b cycle=%0d",
                   words, Out_Index, Out_Data, Out_Last, c, words, 16'h1000 + 16'(words), words == 7, 2 * words + 1);
        end
        words++;
      end
      tick();
    end
    tests++;
    if (words != 8 || dones != 1) begin
      fails++;
      $display("FAIL full_counts: got words=%0d dones=%0d, want 8 and 1", words, dones);
    end
    tests++;
    if (Checksum !== 16'h801C || Busy !== 1'b0) begin
      fails++;
      $display("FAIL full_checksum: got cs=%h busy=%b, want 801c and 0", Checksum, Busy);
    end
  endtask

  task automatic test_zero_mask();
    int valids = 0;
    Mask = 8'h00;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tests++;
    if (Done !== 1'b1 || Busy !== 1'b1 || Out_Valid !== 1'b0 || Checksum !== 16'h0000) begin
      fails++;
      $display("FAIL zero_done: got done=%b busy=%b valid=%b cs=%h, want 1 1 0 0000", Done, Busy, Out_Valid, Checksum);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (Out_Valid || Done) valids++;
    end
    tests++;
    if (valids != 0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_after: got extra valid/done=%0d busy=%b, want 0 and 0", valids, Busy);
    end
  endtask

  task automatic test_stall();
    rf[2] = 16'hFFFF;
    rf[5] = 16'h0002;
    Out_Ready = 1'b0;
    Mask = 8'h24;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      Start = 1'b1;
      Mask = 8'hFF;
      tests++;
      if (Out_Valid !== 1'b1 || Out_Data !== 16'hFFFF || Out_Index !== 3'd2 || Out_Last !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d: got v=%b d=%h i=%0d l=%b, want 1 ffff 2 0", c, Out_Valid, Out_Data, Out_Index, Out_Last);
      end
      tick();
    end
    Start = 1'b0;
    Out_Ready = 1'b1;
    tick();
    tests++;
    if (Out_Valid !== 1'b0 || Checksum !== 16'hFFFF) begin
      fails++;
      $display("FAIL stall_load: got v=%b cs=%h, want 0 ffff", Out_Valid, Checksum);
    end
    tick();
    tests++;
    if (Out_Valid !== 1'b1 || Out_Data !== 16'h0002 || Out_Index !== 3'd5 || Out_Last !== 1'b1) begin
      fails++;
      $display("FAIL stall_second: got v=%b d=%h i=%0d l=%b, want 1 0002 5 1", Out_Valid, Out_Data, Out_Index, Out_Last);
    end
    tick();
    tests++;
    if (Done !== 1'b1 || Checksum !== 16'h0001) begin
      fails++;
      $display("FAIL stall_done: got done=%b cs=%h, want 1 0001", Done, Checksum);
    end
    tick();
    tick();
    tick();
    tests++;
    if (Busy !== 1'b0 || Checksum !== 16'h0001) begin
      fails++;
      $display("FAIL stall_hold_cs: got busy=%b cs=%h, want 0 0001", Busy, Checksum);
    end
  endtask

  task automatic test_write_pending();
    rf[2] = 16'h1111;
    rf[3] = 16'h0000;
    Out_Ready = 1'b0;
    Mask = 8'h0C;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    rf[3] = 16'hBEEF;
    tests++;
    if (Out_Valid !== 1'b1 || Out_Data !== 16'h1111 || Out_Index !== 3'd2) begin
      fails++;
      $display("FAIL wp_first: got v=%b d=%h i=%0d, want 1 1111 2", Out_Valid, Out_Data, Out_Index);
    end
    Out_Ready = 1'b1;
    tick();
    rf[2] = 16'h0000;
    tick();
    tests++;
    if (Out_Valid !== 1'b1 || Out_Data !== 16'hBEEF || Out_Index !== 3'd3 || Out_Last !== 1'b1) begin
      fails++;
      $display("FAIL wp_second: got v=%b d=%h i=%0d l=%b, want 1 beef 3 1", Out_Valid, Out_Data, Out_Index, Out_Last);
    end
    tick();
    tests++;
    if (Done !== 1'b1 || Checksum !== 16'hD000) begin
      fails++;
      $display("FAIL wp_checksum: got done=%b cs=%h, want 1 d000", Done, Checksum);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 0;
    int dones = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    Out_Ready = 1'b1;
    Mask = 8'hFF;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (Out_Valid && Out_Index == 3'd2) hit = 1;
      else tick();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_reach: word index 2 never reached SEND");
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests++;
    if ({SR_ADDR, Out_Valid, Out_Data, Out_Index, Out_Last, Busy, Done, Checksum} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b cs=%h, want all 0",
               SR_ADDR, Out_Valid, Out_Data, Out_Index, Out_Last, Busy, Done, Checksum);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (Done || Out_Valid) dones++;
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL mid_no_done: got %0d done/valid cycles, want 0", dones);
    end
    Mask = 8'h80;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tests++;
    if (Out_Valid !== 1'b1 || Out_Data !== 16'h1007 || Out_Index !== 3'd7 || Out_Last !== 1'b1) begin
      fails++;
      $display("FAIL mid_restart: got v=%b d=%h i=%0d l=%b, want 1 1007 7 1", Out_Valid, Out_Data, Out_Index, Out_Last);
    end
    tick();
    tests++;
    if (Done !== 1'b1 || Checksum !== 16'h1007) begin
      fails++;
      $display("FAIL mid_restart_done: got done=%b cs=%h, want 1 1007", Done, Checksum);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    test_reset();
    test_full_dump();
    test_zero_mask();
    test_stall();
    test_write_pending();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
